nes_multipad_reader: RTL and testbench
======================================

// Module: nes_multipad_reader
// PURPOSE
//  Parametrised successor to the single-pad NES reader. Polls NUM_PADS serial
//  shift-register pads (NES 8-bit or SNES 16-bit) over shared latch/clock lines.
//  Captures all pads in one frame, converts them to active-high, and flags per-pad changes.
//  Feeds the input-port register block of the console core.
// PARAMETERS
//  CLK_FREQ_HZ     27_000_000  system clock frequency
//  POLL_HZ         60          automatic poll rate
//  HALF_PERIOD_US  6           pad clock half-period; latch pulse = 2 half-periods
//  NUM_PADS        2           number of pads (1..4), one serial input each
//  NUM_BITS        8           bits per pad: 8 = NES, 16 = SNES
//  Derived: H = CLK_FREQ_HZ/1_000_000*HALF_PERIOD_US (>=1); POLL_CYC = CLK_FREQ_HZ/POLL_HZ
//           NB = NUM_BITS (+1 with NES_PAD_DETECT_EN); frame = 2H + NB*2H cycles, must be < POLL_CYC
// PORTS
//  i_clk          in   1              system clock, all logic on rising edge
//  i_rst_n        in   1              synchronous reset, active-low
//  i_poll_req     in   1              request an immediate frame (honoured only in IDLE)
//  i_serial_data  in   NUM_PADS       pad data lines, active-low (0 = pressed)
//  o_data_latch   out  1              shared latch to all pads
//  o_data_clock   out  1              shared shift clock; idle low
//  o_buttons      out  NUM_PADS*NUM_BITS  pad p at [p*NUM_BITS +: NUM_BITS], 1 = pressed;
//                                     bit k = k-th serial bit (NES: A,B,Sel,Start,U,D,L,R)
//  o_valid        out  1              1-cycle pulse when o_buttons is updated
//  o_changed      out  NUM_PADS       per-pad flag, valid with o_valid: new value != previous
//  o_busy         out  1              high from LATCH entry through DONE
//  o_connected    out  NUM_PADS       pad-present flags (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (i_rst_n=0 at a clock edge): all outputs 0 except o_connected (see CONFIGURATION).
//    The poll counter is cleared; FSM -> IDLE.
//    A reset mid-frame aborts the frame immediately; no partial o_buttons update.
//  - Poll counter: free-running 0..POLL_CYC-1. Tick when it reaches POLL_CYC-1,
//    so the first tick occurs POLL_CYC cycles after reset release.
//  - Start condition: tick or i_poll_req while in IDLE starts a frame.
//    A tick or request arriving outside IDLE is dropped, not queued.
//    A simultaneous tick and request start a single frame.
//  - FSM IDLE -> LATCH -> SHIFT -> DONE -> IDLE.
//    LATCH: o_data_latch=1 for exactly 2H cycles; o_data_clock=0.
//    SHIFT: bit index k runs 0..NB-1; each bit lasts 2H cycles.
//      Low phase (H cycles): o_data_clock=0. On the last low cycle, sample
//        ~i_serial_data[p] into shadow[p][k] for every pad.
//      High phase (H cycles): o_data_clock=1.
//      k wraps to DONE after the high phase of bit NB-1.
//    DONE (1 cycle): o_buttons <= shadow (bits 0..NUM_BITS-1); o_valid=1;
//      o_changed[p] = (new pad p != old pad p). o_changed is 0 whenever o_valid=0.
//  - o_buttons holds its value between frames. It changes only in DONE.
//  - Latency: request accepted in IDLE -> o_valid exactly 2H + NB*2H + 1 cycles later.
//  - Sub-counters are sized with $clog2. No arithmetic overflow is permitted
//    for any legal parameter set.
// CONFIGURATION
//  NES_PAD_DETECT_EN defined:
//    - NB = NUM_BITS+1; one extra bit (index NUM_BITS) is shifted per frame.
//    - A genuine pad drives its 4021 serial input to 0; an unplugged line is pulled up to 1.
//    - In DONE: o_connected[p] = (raw extra bit == 0).
//    - For a disconnected pad, o_buttons for that pad is forced to 0; o_changed is evaluated on the forced value.
//    - Reset value of o_connected: 0.
//  NES_PAD_DETECT_EN undefined:
//    - NB = NUM_BITS; no extra bit is shifted.
//    - o_connected is constant all-ones, including during reset.
// TESTING  (CLK_FREQ_HZ=1_000_000, HALF_PERIOD_US=2 -> H=2, POLL_HZ=10_000 -> POLL_CYC=100,
//           NUM_PADS=2, NUM_BITS=8, macro undefined unless stated)
//  1 Reset, pad model 0 returns A+Start (serial 0 on bits 0,3), pad 1 all released ->
//    latch high 4 cycles, 8 clock pulses;
//    o_valid at cycle 37 after frame start; o_buttons=16'h0009; o_changed=2'b01.
//  2 Repeat same pad data next frame -> o_valid pulses; o_buttons=16'h0009; o_changed=2'b00.
//  3 i_poll_req pulse while o_busy=1 -> ignored: exactly one o_valid, no frame restart.
//    i_poll_req in IDLE -> o_data_latch rises on the next cycle.
//  4 Assert i_rst_n=0 at SHIFT bit 4 -> next cycle latch=0, clock=0, o_buttons=0, o_busy=0.
//    First tick 100 cycles after release.
//  5 NUM_BITS=16 (SNES), pad 0 presses B,Y (bits 0,1) -> 16 clock pulses; o_buttons[15:0]=16'h0003.
//  6 Macro defined, pad 1 line tied high, pad 0 extra bit 0 -> o_connected=2'b01;
//    o_buttons[15:8]=0; 9 clock pulses per frame.

Source files
------------

// File: rtl/nes_multipad_reader.sv
// nes_multipad_reader: polls NUM_PADS NES/SNES shift-register pads over shared latch/clock lines.
// Define NES_PAD_DETECT_EN to shift one extra bit per frame and report pad presence on o_connected.
module nes_multipad_reader #(
    parameter int CLK_FREQ_HZ    = 27_000_000,
    parameter int POLL_HZ        = 60,
    parameter int HALF_PERIOD_US = 6,
    parameter int NUM_PADS       = 2,
    parameter int NUM_BITS       = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_poll_req,
    input  logic [NUM_PADS-1:0]          i_serial_data,
    output logic                         o_data_latch,
    output logic                         o_data_clock,
    output logic [NUM_PADS*NUM_BITS-1:0] o_buttons,
    output logic                         o_valid,
    output logic [NUM_PADS-1:0]          o_changed,
    output logic                         o_busy,
    output logic [NUM_PADS-1:0]          o_connected
);
    localparam int H_RAW = CLK_FREQ_HZ / 1_000_000 * HALF_PERIOD_US;
    localparam int H = H_RAW < 1 ? 1 : H_RAW;
    localparam int POLL_CYC = CLK_FREQ_HZ / POLL_HZ;
`ifdef NES_PAD_DETECT_EN
    localparam int DET = 1;
`else
    localparam int DET = 0;
`endif
    localparam int NB = NUM_BITS + DET;
    localparam int PW = POLL_CYC > 1 ? $clog2(POLL_CYC) : 1;
    localparam int CW = $clog2(2 * H);
    localparam int BW = NB > 1 ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

    state_t                       state, state_next;
    logic [PW-1:0]                poll_cnt;
    logic [CW-1:0]                ph_cnt;
    logic [BW-1:0]                bit_idx;
    logic [NB-1:0]                shadow [NUM_PADS];
    logic                         tick, ph_last, bit_last, enter_done;
    logic [NUM_PADS*NUM_BITS-1:0] new_buttons;
    logic [NUM_PADS-1:0]          new_changed, pad_present;

    assign tick       = poll_cnt == PW'(POLL_CYC - 1);
    assign ph_last    = ph_cnt == CW'(2 * H - 1);
    assign bit_last   = bit_idx == BW'(NB - 1);
    assign enter_done = state == SHIFT && ph_last && bit_last;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) poll_cnt <= '0;
        else poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (tick || i_poll_req) ? LATCH : IDLE;
            LATCH:   state_next = ph_last ? SHIFT : LATCH;
            SHIFT:   state_next = (ph_last && bit_last) ? DONE : SHIFT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_data_latch = state == LATCH;
        o_data_clock = state == SHIFT && ph_cnt >= CW'(H);
        o_busy       = state != IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ph_cnt  <= '0;
            bit_idx <= '0;
        end else begin
            ph_cnt  <= ((state == LATCH || state == SHIFT) && !ph_last) ? ph_cnt + 1'b1 : '0;
            bit_idx <= state != SHIFT ? '0 : (ph_last && !bit_last) ? bit_idx + 1'b1 : bit_idx;
        end
    end

    // Sample on the last low cycle, just before the pad sees the rising shift clock.
    always_ff @(posedge i_clk) begin
        if (state == SHIFT && ph_cnt == CW'(H - 1))
            for (int p = 0; p < NUM_PADS; p++) shadow[p][bit_idx] <= ~i_serial_data[p];
    end

    always_comb begin
        new_buttons = '0;
        new_changed = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            new_buttons[p*NUM_BITS +: NUM_BITS] = pad_present[p] ? shadow[p][NUM_BITS-1:0] : '0;
            new_changed[p] = new_buttons[p*NUM_BITS +: NUM_BITS] != o_buttons[p*NUM_BITS +: NUM_BITS];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_buttons <= '0;
            o_valid   <= 1'b0;
            o_changed <= '0;
        end else begin
            o_valid   <= enter_done;
            o_changed <= enter_done ? new_changed : '0;
            if (enter_done) o_buttons <= new_buttons;
        end
    end

`ifdef NES_PAD_DETECT_EN
    // Extra bit is stored inverted: a genuine pad shifts in 0, which lands here as 1.
    always_comb begin
        pad_present = '0;
        for (int p = 0; p < NUM_PADS; p++) pad_present[p] = shadow[p][NUM_BITS];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) o_connected <= '0;
        else if (enter_done) o_connected <= pad_present;
    end
`else
    assign pad_present = '1;
    assign o_connected = '1;
`endif
endmodule

// File: tb/tb_nes_multipad_reader.sv
// tb_nes_multipad_reader: directed checks of an 8-bit and a 16-bit reader against 4021-style pad models.
module tb_nes_multipad_reader;
`ifdef NES_PAD_DETECT_EN
    localparam int DET = 1;
`else
    localparam int DET = 0;
`endif
    localparam int NB8 = 8 + DET;
    localparam int NB16 = 16 + DET;
    localparam int VAT8 = 4 + 4 * NB8 + 1;
    localparam int VAT16 = 4 + 4 * NB16 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, req8 = 1'b0, req16 = 1'b0;
    logic [1:0]  sd8, sd16, ch8, ch16, con8, con16;
    logic        latch8, ck8, valid8, busy8, latch16, ck16, valid16, busy16;
    logic [15:0] btn8;
    logic [31:0] btn16;
    logic [7:0]  pad8 [2];
    logic [15:0] pad16 [2];
    logic [1:0]  ext8 = 2'b00, ext16 = 2'b00;
    logic [5:0]  pc8 = 6'd0, pc16 = 6'd0;
    logic        ck8_d = 1'b0, ck16_d = 1'b0;

    int n_cmp = 0, n_fail = 0;
    int lat, pulses, vcnt, vat, chg_bad, early;
    logic [31:0] cap_b;
    logic [1:0]  cap_ch;

    nes_multipad_reader #(.CLK_FREQ_HZ(1_000_000), .POLL_HZ(10_000), .HALF_PERIOD_US(2),
                          .NUM_PADS(2), .NUM_BITS(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_poll_req(req8), .i_serial_data(sd8),
        .o_data_latch(latch8), .o_data_clock(ck8), .o_buttons(btn8), .o_valid(valid8),
        .o_changed(ch8), .o_busy(busy8), .o_connected(con8));

    nes_multipad_reader #(.CLK_FREQ_HZ(1_000_000), .POLL_HZ(10_000), .HALF_PERIOD_US(2),
                          .NUM_PADS(2), .NUM_BITS(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_poll_req(req16), .i_serial_data(sd16),
        .o_data_latch(latch16), .o_data_clock(ck16), .o_buttons(btn16), .o_valid(valid16),
        .o_changed(ch16), .o_busy(busy16), .o_connected(con16));

    // Pad models: latch reloads, each rising shift clock advances one bit, then the serial-in bit follows.
    always @(negedge clk) begin
        pc8 = latch8 ? 6'd0 : (ck8 && !ck8_d) ? pc8 + 6'd1 : pc8;
        ck8_d = ck8;
        pc16 = latch16 ? 6'd0 : (ck16 && !ck16_d) ? pc16 + 6'd1 : pc16;
        ck16_d = ck16;
    end

    always_comb begin
        sd8 = 2'b11;
        sd16 = 2'b11;
        for (int p = 0; p < 2; p++) begin
            sd8[p] = pc8 < 6'd8 ? ~pad8[p][pc8[2:0]] : ext8[p];
            sd16[p] = pc16 < 6'd16 ? ~pad16[p][pc16[3:0]] : ext16[p];
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req8 = 1'b0;
        req16 = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic measure(input bit big, input int ncyc, input int req_at);
        logic l, c, v, cprev;
        logic [1:0] ch;
        lat = 0; pulses = 0; vcnt = 0; vat = -1; chg_bad = 0; cprev = 1'b0;
        for (int i = 1; i <= ncyc; i++) begin
            step(1);
            req8 = 1'b0;
            req16 = 1'b0;
            if (i == req_at) begin
                if (big) req16 = 1'b1;
                else req8 = 1'b1;
            end
            l = big ? latch16 : latch8;
            c = big ? ck16 : ck8;
            v = big ? valid16 : valid8;
            ch = big ? ch16 : ch8;
            if (l) lat++;
            if (c && !cprev) pulses++;
            cprev = c;
            if (v) begin
                vcnt++;
                if (vat < 0) vat = i;
                cap_b = big ? btn16 : {16'h0000, btn8};
                cap_ch = ch;
            end else if (ch != 2'b00) chg_bad++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        n_cmp++; if (latch8 !== 1'b0) begin n_fail++; $display("FAIL reset_latch got=%b exp=0", latch8); end
        n_cmp++; if (ck8 !== 1'b0) begin n_fail++; $display("FAIL reset_clock got=%b exp=0", ck8); end
        n_cmp++; if (btn8 !== 16'h0000) begin n_fail++; $display("FAIL reset_buttons got=%h exp=0000", btn8); end
        n_cmp++; if ({valid8, ch8, busy8} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {valid8, ch8, busy8}); end
        n_cmp++; if (con8 !== (DET ? 2'b00 : 2'b11)) begin n_fail++; $display("FAIL reset_connected got=%b exp=%b", con8, DET ? 2'b00 : 2'b11); end
        n_cmp++; if ({btn16, busy16, valid16, con16} !== {32'h0, 2'b00, DET ? 2'b00 : 2'b11}) begin n_fail++; $display("FAIL reset_snes got=%h/%b/%b exp=0/0/%b", btn16, busy16, con16, DET ? 2'b00 : 2'b11); end
        rst_n = 1'b1;
    endtask

    task automatic test_first_frame();
        do_reset();
        pad8[0] = 8'h09; pad8[1] = 8'h00;
        req8 = 1'b1;
        measure(0, 45, 0);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL first_latch_cycles got=%0d exp=4", lat); end
        n_cmp++; if (pulses !== NB8) begin n_fail++; $display("FAIL first_pulses got=%0d exp=%0d", pulses, NB8); end
        n_cmp++; if (vat !== VAT8 || vcnt !== 1) begin n_fail++; $display("FAIL first_valid got=@%0d x%0d exp=@%0d x1", vat, vcnt, VAT8); end
        n_cmp++; if (cap_b !== 32'h0009) begin n_fail++; $display("FAIL first_buttons got=%h exp=0009", cap_b); end
        n_cmp++; if (cap_ch !== 2'b01) begin n_fail++; $display("FAIL first_changed got=%b exp=01", cap_ch); end
        n_cmp++; if (chg_bad !== 0) begin n_fail++; $display("FAIL first_changed_idle got=%0d exp=0", chg_bad); end
        n_cmp++; if (btn8 !== 16'h0009) begin n_fail++; $display("FAIL first_hold got=%h exp=0009", btn8); end
    endtask

    task automatic test_repeat_frame();
        req8 = 1'b1;
        measure(0, 45, 0);
        n_cmp++; if (vcnt !== 1) begin n_fail++; $display("FAIL repeat_valid got=%0d exp=1", vcnt); end
        n_cmp++; if (cap_b !== 32'h0009) begin n_fail++; $display("FAIL repeat_buttons got=%h exp=0009", cap_b); end
        n_cmp++; if (cap_ch !== 2'b00) begin n_fail++; $display("FAIL repeat_changed got=%b exp=00", cap_ch); end
    endtask

    task automatic test_busy_request();
        do_reset();
        pad8[0] = 8'h09; pad8[1] = 8'h00;
        req8 = 1'b1;
        measure(0, 80, 10);
        n_cmp++; if (vcnt !== 1) begin n_fail++; $display("FAIL busy_req_valid got=%0d exp=1", vcnt); end
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL busy_req_latch got=%0d exp=4", lat); end
        req8 = 1'b1;
        step(1);
        req8 = 1'b0;
        n_cmp++; if (latch8 !== 1'b1) begin n_fail++; $display("FAIL idle_req_latch got=%b exp=1", latch8); end
        measure(0, 60, 0);
        n_cmp++; if (vcnt !== 1 || lat !== 3) begin n_fail++; $display("FAIL tick_in_busy got=x%0d lat%0d exp=x1 lat3", vcnt, lat); end
    endtask

    task automatic test_changed();
        do_reset();
        pad8[0] = 8'h09; pad8[1] = 8'h80;
        req8 = 1'b1;
        measure(0, 45, 0);
        n_cmp++; if ({cap_b[15:0], cap_ch} !== {16'h8009, 2'b11}) begin n_fail++; $display("FAIL changed_both got=%h/%b exp=8009/11", cap_b[15:0], cap_ch); end
        pad8[0] = 8'h00;
        req8 = 1'b1;
        measure(0, 45, 0);
        n_cmp++; if ({cap_b[15:0], cap_ch} !== {16'h8000, 2'b01}) begin n_fail++; $display("FAIL changed_pad0 got=%h/%b exp=8000/01", cap_b[15:0], cap_ch); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pad8[0] = 8'h09; pad8[1] = 8'h00;
        step(99);
        req8 = 1'b1;
        measure(0, 60, 0);
        n_cmp++; if (vcnt !== 1 || lat !== 4) begin n_fail++; $display("FAIL simul_single got=x%0d lat%0d exp=x1 lat4", vcnt, lat); end
        n_cmp++; if (vat !== VAT8 || cap_b !== 32'h0009) begin n_fail++; $display("FAIL simul_frame got=@%0d %h exp=@%0d 0009", vat, cap_b, VAT8); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        pad8[0] = 8'h09; pad8[1] = 8'h00;
        req8 = 1'b1;
        measure(0, 45, 0);
        n_cmp++; if (btn8 !== 16'h0009) begin n_fail++; $display("FAIL abort_pre_buttons got=%h exp=0009", btn8); end
        req8 = 1'b1;
        step(1);
        req8 = 1'b0;
        step(22);
        n_cmp++; if (ck8 !== 1'b1) begin n_fail++; $display("FAIL abort_bit4_clock got=%b exp=1", ck8); end
        rst_n = 1'b0;
        step(1);
        n_cmp++; if ({latch8, ck8, busy8, valid8} !== 4'b0000) begin n_fail++; $display("FAIL abort_lines got=%b exp=0000", {latch8, ck8, busy8, valid8}); end
        n_cmp++; if (btn8 !== 16'h0000) begin n_fail++; $display("FAIL abort_buttons got=%h exp=0000", btn8); end
        rst_n = 1'b1;
        early = 0;
        for (int i = 1; i <= 99; i++) begin
            step(1);
            if (latch8 || valid8) early++;
        end
        n_cmp++; if (early !== 0) begin n_fail++; $display("FAIL abort_early_tick got=%0d exp=0", early); end
        step(1);
        n_cmp++; if (latch8 !== 1'b1) begin n_fail++; $display("FAIL abort_first_tick got=%b exp=1", latch8); end
    endtask

    task automatic test_snes();
        do_reset();
        pad16[0] = 16'h0003; pad16[1] = 16'h0000;
        req16 = 1'b1;
        measure(1, 80, 0);
        n_cmp++; if (pulses !== NB16 || lat !== 4) begin n_fail++; $display("FAIL snes_pulses got=%0d lat%0d exp=%0d lat4", pulses, lat, NB16); end
        n_cmp++; if (vat !== VAT16 || vcnt !== 1) begin n_fail++; $display("FAIL snes_valid got=@%0d x%0d exp=@%0d x1", vat, vcnt, VAT16); end
        n_cmp++; if (cap_b !== 32'h0000_0003) begin n_fail++; $display("FAIL snes_buttons got=%h exp=00000003", cap_b); end
        n_cmp++; if (cap_ch !== 2'b01) begin n_fail++; $display("FAIL snes_changed got=%b exp=01", cap_ch); end
    endtask

    task automatic test_detect();
        do_reset();
        pad8[0] = 8'h09; ext8[0] = 1'b0;
        pad8[1] = 8'h55; ext8[1] = 1'b1;
        req8 = 1'b1;
        measure(0, 45, 0);
`ifdef NES_PAD_DETECT_EN
        n_cmp++; if (pulses !== 9) begin n_fail++; $display("FAIL detect_pulses got=%0d exp=9", pulses); end
        n_cmp++; if (con8 !== 2'b01) begin n_fail++; $display("FAIL detect_connected got=%b exp=01", con8); end
        n_cmp++; if ({cap_b[15:0], cap_ch} !== {16'h0009, 2'b01}) begin n_fail++; $display("FAIL detect_forced got=%h/%b exp=0009/01", cap_b[15:0], cap_ch); end
        ext8[1] = 1'b0;
        req8 = 1'b1;
        measure(0, 45, 0);
        n_cmp++; if ({con8, cap_b[15:0], cap_ch} !== {2'b11, 16'h5509, 2'b10}) begin n_fail++; $display("FAIL detect_plugged got=%b/%h/%b exp=11/5509/10", con8, cap_b[15:0], cap_ch); end
`else
        n_cmp++; if ({con8, cap_b[15:0]} !== {2'b11, 16'h5509}) begin n_fail++; $display("FAIL nodetect got=%b/%h exp=11/5509", con8, cap_b[15:0]); end
`endif
        ext8 = 2'b00;
    endtask

    initial begin
        pad8 = '{8'h00, 8'h00};
        pad16 = '{16'h0000, 16'h0000};
        test_reset();
        test_first_frame();
        test_repeat_frame();
        test_busy_request();
        test_changed();
        test_simultaneous();
        test_reset_mid_frame();
        test_snes();
        test_detect();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
